// File: rtl/p_dispatch_pkg.sv
// Types and constants shared by the rename (R), dispatch (P) and issue stages.
package p_dispatch_pkg;

    localparam int DECODE_WIDTH = 2;
    localparam int ROB_DEPTH    = 64;
    localparam int CDB_PORTS    = 2;
    localparam int SRC_PER_SLOT = 2;
    localparam int ROB_ID_W     = $clog2(ROB_DEPTH);
    localparam int CTRL_W       = 16;
    localparam int ROB_RD_PORTS = DECODE_WIDTH * SRC_PER_SLOT;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    // Source operand as produced by rename
    typedef struct packed {
        logic [31:0] arf_data;
        rob_id_t     rob_id;
        logic        renamed;
    } r_src_t;

    // Source operand as handed to issue
    typedef struct packed {
        logic [31:0] data;
        rob_id_t     rob_id;
        logic        ready;
    } src_operand_t;

    typedef struct packed {
        logic                           valid;
        logic [CTRL_W-1:0]              ctrl;
        rob_id_t                        dest;
        r_src_t [SRC_PER_SLOT-1:0]      src;
    } r_slot_t;

    typedef struct packed {
        logic                           valid;
        logic [CTRL_W-1:0]              ctrl;
        rob_id_t                        dest;
        src_operand_t [SRC_PER_SLOT-1:0] src;
    } p_slot_t;

    typedef struct packed {
        r_slot_t [DECODE_WIDTH-1:0] slot;
    } r_p_pkt_t;

    typedef struct packed {
        p_slot_t [DECODE_WIDTH-1:0] slot;
    } p_i_pkt_t;

    // An unrenamed source is ready with its architectural value; a renamed one starts waiting
    function automatic src_operand_t src_from_rename(r_src_t s);
        src_operand_t o;
        o.data   = s.arf_data;
        o.rob_id = s.rob_id;
        o.ready  = ~s.renamed;
        return o;
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Generic valid/ready handshake carrying a payload of type T.
interface handshake_if #(parameter type T = logic);
    logic valid;
    logic ready;
    T     data;

    modport sender   (output valid, output data, input ready);
    modport receiver (input valid, input data, output ready);
endinterface

// File: rtl/p_operand_wakeup.sv
// Combinational resolver for one source operand: CDB beats ROB, lowest CDB port wins.
module p_operand_wakeup
    import p_dispatch_pkg::*;
(
    input  src_operand_t                    cur_op,
    input  logic                            rob_valid,
    input  logic [31:0]                     rob_data,
    input  logic [CDB_PORTS-1:0]            cdb_valid,
    input  rob_id_t [CDB_PORTS-1:0]         cdb_rob_id,
    input  logic [CDB_PORTS-1:0][31:0]      cdb_data,
    output src_operand_t                    res_op
);

    logic        cdb_hit_s;
    logic [31:0] cdb_hit_data_s;

    // Scan ports from highest to lowest so the lowest matching port is the final winner
    always_comb begin
        cdb_hit_s      = 1'b0;
        cdb_hit_data_s = 32'h0000_0000;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_rob_id[p] == cur_op.rob_id)) begin
                cdb_hit_s      = 1'b1;
                cdb_hit_data_s = cdb_data[p];
            end else begin
                cdb_hit_s      = cdb_hit_s;
                cdb_hit_data_s = cdb_hit_data_s;
            end
        end
    end

    // Ready operands pass untouched; a CDB hit wins because the ROB write is not yet visible
    always_comb begin
        res_op = cur_op;
        if (cur_op.ready) begin
            res_op = cur_op;
        end else if (cdb_hit_s) begin
            res_op.data  = cdb_hit_data_s;
            res_op.ready = 1'b1;
        end else if (rob_valid) begin
            res_op.data  = rob_data;
            res_op.ready = 1'b1;
        end else begin
            res_op = cur_op;
        end
    end

endmodule

// File: rtl/p_dispatch.sv
// Dispatch stage: resolves renamed operands, buffers bundles in a small skid FIFO
// that keeps snooping the CDB, and hands them to issue.
module p_dispatch
    import p_dispatch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
)
(
    input  logic                                clk,
    input  logic                                rst_n,
    handshake_if.receiver                       r_p_receiver,
    handshake_if.sender                         p_i_sender,
    output rob_id_t [ROB_RD_PORTS-1:0]          rob_raddr_o,
    input  logic [ROB_RD_PORTS-1:0][31:0]       rob_rdata_i,
    input  logic [ROB_RD_PORTS-1:0]             rob_rvalid_i,
    input  logic [CDB_PORTS-1:0]                cdb_valid_i,
    input  rob_id_t [CDB_PORTS-1:0]             cdb_rob_id_i,
    input  logic [CDB_PORTS-1:0][31:0]          cdb_data_i,
    input  logic                                c_flush_i,
    output logic                                c_flush_ack_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    r_p_pkt_t       in_pkt_s;
    p_i_pkt_t       enq_pkt_s;
    p_i_pkt_t       buf_r      [BUF_DEPTH];
    p_i_pkt_t       woken_s    [BUF_DEPTH];
    src_operand_t   enq_cur_s  [DECODE_WIDTH][SRC_PER_SLOT];
    src_operand_t   enq_src_s  [DECODE_WIDTH][SRC_PER_SLOT];
    src_operand_t   wake_src_s [BUF_DEPTH][DECODE_WIDTH][SRC_PER_SLOT];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             flush_ack_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             enq_s;
    logic             deq_s;

    assign in_pkt_s = r_p_receiver.data;

    // Resolve every incoming source against ROB and CDB; ROB addresses follow the bundle regardless of valid
    for (genvar s = 0; s < DECODE_WIDTH; s++) begin : g_enq_slot
        for (genvar k = 0; k < SRC_PER_SLOT; k++) begin : g_enq_src
            assign rob_raddr_o[s*SRC_PER_SLOT+k] = in_pkt_s.slot[s].src[k].rob_id;
            assign enq_cur_s[s][k] = src_from_rename(in_pkt_s.slot[s].src[k]);
            p_operand_wakeup u_enq_resolve (
                .cur_op     (enq_cur_s[s][k]),
                .rob_valid  (rob_rvalid_i[s*SRC_PER_SLOT+k]),
                .rob_data   (rob_rdata_i[s*SRC_PER_SLOT+k]),
                .cdb_valid  (cdb_valid_i),
                .cdb_rob_id (cdb_rob_id_i),
                .cdb_data   (cdb_data_i),
                .res_op     (enq_src_s[s][k])
            );
        end
    end

    // Buffered operands only wake from the CDB; their ROB lookup happened at enqueue
    for (genvar e = 0; e < BUF_DEPTH; e++) begin : g_buf_entry
        for (genvar s = 0; s < DECODE_WIDTH; s++) begin : g_buf_slot
            for (genvar k = 0; k < SRC_PER_SLOT; k++) begin : g_buf_src
                p_operand_wakeup u_buf_wakeup (
                    .cur_op     (buf_r[e].slot[s].src[k]),
                    .rob_valid  (1'b0),
                    .rob_data   (32'h0000_0000),
                    .cdb_valid  (cdb_valid_i),
                    .cdb_rob_id (cdb_rob_id_i),
                    .cdb_data   (cdb_data_i),
                    .res_op     (wake_src_s[e][s][k])
                );
            end
        end
    end

    // Assemble the resolved incoming bundle and the woken copy of each stored entry
    always_comb begin
        enq_pkt_s = '0;
        for (int s = 0; s < DECODE_WIDTH; s++) begin
            enq_pkt_s.slot[s].valid = in_pkt_s.slot[s].valid;
            enq_pkt_s.slot[s].ctrl  = in_pkt_s.slot[s].ctrl;
            enq_pkt_s.slot[s].dest  = in_pkt_s.slot[s].dest;
            for (int k = 0; k < SRC_PER_SLOT; k++) begin
                enq_pkt_s.slot[s].src[k] = enq_src_s[s][k];
            end
        end
        for (int e = 0; e < BUF_DEPTH; e++) begin
            woken_s[e] = buf_r[e];
            for (int s = 0; s < DECODE_WIDTH; s++) begin
                for (int k = 0; k < SRC_PER_SLOT; k++) begin
                    woken_s[e].slot[s].src[k] = wake_src_s[e][s][k];
                end
            end
        end
    end

    // Ready ignores the downstream ready so a full buffer never accepts in the cycle it drains
    assign in_ready_s  = (count_r != CNT_W'(BUF_DEPTH)) && !c_flush_i;
    assign out_valid_s = (count_r != {CNT_W{1'b0}}) && !c_flush_i;
    assign enq_s       = r_p_receiver.valid && in_ready_s;
    assign deq_s       = out_valid_s && p_i_sender.ready;

    assign r_p_receiver.ready = in_ready_s;
    assign p_i_sender.valid   = out_valid_s;
    assign p_i_sender.data    = buf_r[head_r];
    assign c_flush_ack_o      = flush_ack_r;

    // Pointers and occupancy; a flush empties the buffer and blocks any transfer that edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (c_flush_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end else begin
                tail_r <= tail_r;
            end
            if (deq_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end else begin
                head_r <= head_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Write the new bundle at the tail; every other entry absorbs this cycle's CDB wakeups
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < BUF_DEPTH; e++) begin
                buf_r[e] <= '0;
            end
        end else begin
            for (int e = 0; e < BUF_DEPTH; e++) begin
                if (enq_s && (tail_r == PTR_W'(e))) begin
                    buf_r[e] <= enq_pkt_s;
                end else begin
                    buf_r[e] <= woken_s[e];
                end
            end
        end
    end

    // Flush acknowledge follows the sampled flush request by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_ack_r <= 1'b0;
        end else begin
            flush_ack_r <= c_flush_i;
        end
    end

endmodule

// File: tb/tb_p_dispatch.sv
// Self-checking bench for p_dispatch: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_p_dispatch;
    import p_dispatch_pkg::*;

    localparam int BUF_DEPTH = 2;

    logic clk;
    logic rst_n;

    handshake_if #(.T(r_p_pkt_t)) r_p_if ();
    handshake_if #(.T(p_i_pkt_t)) p_i_if ();

    r_p_pkt_t                       in_pkt;
    logic                           in_valid;
    logic                           out_ready;
    logic                           flush;
    logic                           c_flush_ack;
    logic [CDB_PORTS-1:0]           cv;
    rob_id_t [CDB_PORTS-1:0]        cid;
    logic [CDB_PORTS-1:0][31:0]     cd;
    rob_id_t [ROB_RD_PORTS-1:0]     rob_raddr;
    logic [ROB_RD_PORTS-1:0][31:0]  rob_rdata;
    logic [ROB_RD_PORTS-1:0]        rob_rvalid;

    logic [31:0] rob_mem  [ROB_DEPTH];
    logic        rob_done [ROB_DEPTH];

    p_i_pkt_t q [$];
    logic     ack_exp;
    int       total;
    int       bad;

    assign r_p_if.valid = in_valid;
    assign r_p_if.data  = in_pkt;
    assign p_i_if.ready = out_ready;

    p_dispatch #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_p_receiver (r_p_if),
        .p_i_sender   (p_i_if),
        .rob_raddr_o  (rob_raddr),
        .rob_rdata_i  (rob_rdata),
        .rob_rvalid_i (rob_rvalid),
        .cdb_valid_i  (cv),
        .cdb_rob_id_i (cid),
        .cdb_data_i   (cd),
        .c_flush_i    (flush),
        .c_flush_ack_o(c_flush_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The ROB answers lookups for the sources of the bundle currently presented by rename
    always_comb begin
        for (int i = 0; i < ROB_RD_PORTS; i++) begin
            rob_rdata[i]  = rob_mem[in_pkt.slot[i/SRC_PER_SLOT].src[i%SRC_PER_SLOT].rob_id];
            rob_rvalid[i] = rob_done[in_pkt.slot[i/SRC_PER_SLOT].src[i%SRC_PER_SLOT].rob_id];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hit, data} of the lowest CDB port currently broadcasting id
    function automatic logic [32:0] cdb_lookup(rob_id_t id);
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cv[p] && cid[p] == id) return {1'b1, cd[p]};
        end
        return 33'h0;
    endfunction

    function automatic p_i_pkt_t resolve_pkt(r_p_pkt_t in);
        p_i_pkt_t    o;
        r_src_t      src;
        logic [32:0] c;
        o = '0;
        for (int s = 0; s < DECODE_WIDTH; s++) begin
            o.slot[s].valid = in.slot[s].valid;
            o.slot[s].ctrl  = in.slot[s].ctrl;
            o.slot[s].dest  = in.slot[s].dest;
            for (int k = 0; k < SRC_PER_SLOT; k++) begin
                src = in.slot[s].src[k];
                c   = cdb_lookup(src.rob_id);
                o.slot[s].src[k].rob_id = src.rob_id;
                if (!src.renamed) begin
                    o.slot[s].src[k].data = src.arf_data; o.slot[s].src[k].ready = 1'b1;
                end else if (c[32]) begin
                    o.slot[s].src[k].data = c[31:0]; o.slot[s].src[k].ready = 1'b1;
                end else if (rob_done[src.rob_id]) begin
                    o.slot[s].src[k].data = rob_mem[src.rob_id]; o.slot[s].src[k].ready = 1'b1;
                end else begin
                    o.slot[s].src[k].ready = 1'b0;
                end
            end
        end
        return o;
    endfunction

    function automatic r_p_pkt_t unren(logic [31:0] a, logic [31:0] b, logic [15:0] ctrl);
        r_p_pkt_t p;
        p = '0;
        for (int s = 0; s < DECODE_WIDTH; s++) begin
            p.slot[s].valid           = 1'b1;
            p.slot[s].ctrl            = ctrl + 16'(s);
            p.slot[s].dest            = rob_id_t'(s + 32);
            p.slot[s].src[0].arf_data = a;
            p.slot[s].src[1].arf_data = b;
        end
        return p;
    endfunction

    function automatic r_p_pkt_t rand_pkt();
        r_p_pkt_t p;
        for (int s = 0; s < DECODE_WIDTH; s++) begin
            p.slot[s].valid = 1'($urandom_range(0, 3) != 0);
            p.slot[s].ctrl  = 16'($urandom);
            p.slot[s].dest  = rob_id_t'($urandom);
            for (int k = 0; k < SRC_PER_SLOT; k++) begin
                p.slot[s].src[k].arf_data = $urandom;
                p.slot[s].src[k].rob_id   = rob_id_t'($urandom_range(0, 15));
                p.slot[s].src[k].renamed  = 1'($urandom_range(0, 1));
            end
        end
        return p;
    endfunction

    task automatic compare_head(input p_i_pkt_t e);
        p_i_pkt_t d;
        d = p_i_if.data;
        for (int s = 0; s < DECODE_WIDTH; s++) begin
            chk("slot_valid", 32'(d.slot[s].valid), 32'(e.slot[s].valid));
            if (e.slot[s].valid) begin
                chk("slot_ctrl", 32'(d.slot[s].ctrl), 32'(e.slot[s].ctrl));
                chk("slot_dest", 32'(d.slot[s].dest), 32'(e.slot[s].dest));
                for (int k = 0; k < SRC_PER_SLOT; k++) begin
                    chk("src_ready", 32'(d.slot[s].src[k].ready), 32'(e.slot[s].src[k].ready));
                    chk("src_rob_id", 32'(d.slot[s].src[k].rob_id), 32'(e.slot[s].src[k].rob_id));
                    if (e.slot[s].src[k].ready) chk("src_data", d.slot[s].src[k].data, e.slot[s].src[k].data);
                end
            end
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the coming edge
    task automatic cycle();
        logic        exp_ready, exp_valid, enq, deq;
        p_i_pkt_t    nw, t;
        logic [32:0] c;
        @(negedge clk);
        exp_ready = (q.size() < BUF_DEPTH) && !flush;
        exp_valid = (q.size() != 0) && !flush;
        chk("in_ready", 32'(r_p_if.ready), 32'(exp_ready));
        chk("out_valid", 32'(p_i_if.valid), 32'(exp_valid));
        chk("flush_ack", 32'(c_flush_ack), 32'(ack_exp));
        for (int i = 0; i < ROB_RD_PORTS; i++) begin
            chk("rob_raddr", 32'(rob_raddr[i]), 32'(in_pkt.slot[i/SRC_PER_SLOT].src[i%SRC_PER_SLOT].rob_id));
        end
        if (exp_valid) compare_head(q[0]);
        enq = in_valid && exp_ready;
        deq = exp_valid && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            nw = resolve_pkt(in_pkt);
            for (int j = 0; j < q.size(); j++) begin
                t = q[j];
                for (int s = 0; s < DECODE_WIDTH; s++) begin
                    for (int k = 0; k < SRC_PER_SLOT; k++) begin
                        c = cdb_lookup(t.slot[s].src[k].rob_id);
                        if (t.slot[s].valid && !t.slot[s].src[k].ready && c[32]) begin
                            t.slot[s].src[k].data  = c[31:0];
                            t.slot[s].src[k].ready = 1'b1;
                        end
                    end
                end
                q[j] = t;
            end
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(nw);
        end
        ack_exp = flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; ack_exp = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pkt = '0; cv = '0; cid = '0; cd = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin rob_mem[i] = 32'h0; rob_done[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(p_i_if.valid), 32'h0);
        chk("rst_ack", 32'(c_flush_ack), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(r_p_if.ready), 32'h1);

        // Unrenamed sources, issue always ready: one bundle per cycle
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_pkt = unren(32'h11, 32'h22, 16'(i * 4));
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // CDB beats ROB at enqueue
        rob_mem[5] = 32'hAA; rob_done[5] = 1'b1;
        in_pkt = unren(32'h1, 32'h2, 16'h100);
        in_pkt.slot[0].src[0].renamed = 1'b1; in_pkt.slot[0].src[0].rob_id = rob_id_t'(5);
        cv = 2'b01; cid[0] = rob_id_t'(5); cd[0] = 32'hBB;
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        cv = 2'b00; in_valid = 1'b0;
        chk("cdb_over_rob_data", p_i_if.data.slot[0].src[0].data, 32'hBB);
        chk("cdb_over_rob_ready", 32'(p_i_if.data.slot[0].src[0].ready), 32'h1);
        out_ready = 1'b1;
        cycle();

        // Wakeup while stalled
        in_pkt = unren(32'h3, 32'h4, 16'h200);
        in_pkt.slot[1].src[1].renamed = 1'b1; in_pkt.slot[1].src[1].rob_id = rob_id_t'(9);
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        cv = 2'b10; cid[1] = rob_id_t'(9); cd[1] = 32'hCC;
        cycle();
        cv = 2'b00;
        cycle();
        chk("wakeup_data", p_i_if.data.slot[1].src[1].data, 32'hCC);
        chk("wakeup_ready", 32'(p_i_if.data.slot[1].src[1].ready), 32'h1);
        out_ready = 1'b1;
        cycle();

        // Fill, back-pressure the third bundle, then drain with pointer wrap
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pkt = unren(32'h300 + 32'(i), 32'h400 + 32'(i), 16'(16'h300 + 16'(i * 4)));
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Flush while full
        out_ready = 1'b0; in_valid = 1'b1;
        in_pkt = unren(32'h500, 32'h501, 16'h500); cycle();
        in_pkt = unren(32'h502, 32'h503, 16'h504); cycle();
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_empty_valid", 32'(p_i_if.valid), 32'h0);
        chk("flush_ack_set", 32'(c_flush_ack), 32'h1);
        cycle();
        cycle();

        // Asynchronous reset mid-stream with one entry buffered
        in_valid = 1'b1; in_pkt = unren(32'h600, 32'h601, 16'h600);
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(p_i_if.valid), 32'h0);
        chk("async_rst_ack", 32'(c_flush_ack), 32'h0);
        q.delete(); ack_exp = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1; in_pkt = unren(32'h700, 32'h701, 16'h5A5A);
        cycle();
        in_valid = 1'b0;
        chk("rst_first_out", 32'(p_i_if.data.slot[0].ctrl), 32'h5A5A);
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_pkt    = rand_pkt();
            in_valid  = 1'($urandom_range(0, 9) < 7);
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush     = 1'($urandom_range(0, 29) == 0);
            cv        = CDB_PORTS'($urandom);
            for (int p = 0; p < CDB_PORTS; p++) begin
                cid[p] = rob_id_t'($urandom_range(0, 15));
                cd[p]  = $urandom;
            end
            for (int i = 0; i < 16; i++) begin
                rob_done[i] = 1'($urandom_range(0, 3) == 0);
                rob_mem[i]  = $urandom;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
